// File: rtl/tx_stereo_fifo.sv
// tx_stereo_fifo
//   Transmit FIFO for a stereo (I2S-style) serial output. Words are pushed
//   with a left/right channel tag. On every word-select transition, seen on a
//   bit_en strobe, the head entry is popped and shifted out MSB-first on sdo.
//   Output starts one strobe after the transition, which gives the I2S
//   one-bit delay.
//
// Parameters
//   WIDTH   stored word width (16..32)
//   ADDR    address bits, DEPTH = 2**ADDR
//   AF_LVL  almost_full threshold  (level >= AF_LVL)
//   AE_LVL  almost_empty threshold (level <= AE_LVL)
//
// Ports
//   clk, rst_                  clock, asynchronous active-low reset
//   wr_en, din, wr_ch          push request, word, channel tag (0=L, 1=R)
//   bit_en, ws, frame_16       serial strobe, word select, 16-bit frame mode
//   flush, clr_err             synchronous queue clear, sticky-flag clear
//   sdo                        registered serial data
//   full, empty, almost_full,
//   almost_empty, level        occupancy status
//   overflow, underflow,
//   ch_err                     sticky error flags
module tx_stereo_fifo #(
    parameter int WIDTH  = 32,
    parameter int ADDR   = 3,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_ch,
    input  logic             bit_en,
    input  logic             ws,
    input  logic             frame_16,
    input  logic             flush,
    input  logic             clr_err,
    output logic             sdo,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    level,
    output logic             overflow,
    output logic             underflow,
    output logic             ch_err
);

    localparam int DEPTH = 2 ** ADDR;
    localparam int BW    = $clog2(WIDTH + 1);

    localparam logic [ADDR:0] C_DEPTH = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0] C_AF    = (ADDR + 1)'(AF_LVL);
    localparam logic [ADDR:0] C_AE    = (ADDR + 1)'(AE_LVL);
    localparam logic [BW-1:0] C_BITS_FULL = BW'(WIDTH);
    localparam logic [BW-1:0] C_BITS_16   = BW'(16);

    // Storage: {tag, word}
    logic [WIDTH:0]    r_mem [DEPTH];
    logic [ADDR:0]     r_wptr;
    logic [ADDR:0]     r_rptr;

    // Serializer state
    logic [WIDTH-1:0]  r_shreg;
    logic [BW-1:0]     r_bcnt;
    logic              r_ws_q;
    logic              r_sdo;

    // Sticky flags
    logic              r_ovf;
    logic              r_unf;
    logic              r_cherr;

    logic [ADDR:0]     w_level;
    logic              w_full;
    logic              w_empty;
    logic [WIDTH:0]    w_head;
    logic              w_head_tag;
    logic [WIDTH-1:0]  w_head_word;
    logic [WIDTH-1:0]  w_low16;
    logic [WIDTH-1:0]  w_load_word;
    logic              w_slot;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_cherr_set;

    // Pointers are one bit wider than the address. Their difference is
    // therefore the true occupancy 0..DEPTH, with no ambiguity between
    // full and empty.
    assign w_level = r_wptr - r_rptr;
    assign w_full  = (w_level == C_DEPTH);
    assign w_empty = (w_level == '0);

    assign w_head      = r_mem[r_rptr[ADDR-1:0]];
    assign w_head_tag  = w_head[WIDTH];
    assign w_head_word = w_head[WIDTH-1:0];

    // In 16-bit frame mode the low half-word is left-aligned, so the
    // serializer always shifts from the top bit.
    always_comb begin
        w_low16       = '0;
        w_low16[15:0] = w_head_word[15:0];
        w_load_word   = frame_16 ? (w_low16 << (WIDTH - 16)) : w_head_word;
    end

    assign w_slot      = bit_en && (ws != r_ws_q);
    assign w_push      = wr_en && !w_full && !flush;
    assign w_pop       = w_slot && !w_empty && !flush;
    assign w_ovf_set   = wr_en && w_full && !flush;
    assign w_unf_set   = w_slot && w_empty && !flush;
    assign w_cherr_set = w_pop && (w_head_tag != ws);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[ADDR-1:0]] <= {wr_ch, din};
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Serializer. sdo always takes the current MSB, or 0 once the word has
    // been sent. A slot start then overrides the shift with a fresh load.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_shreg <= '0;
            r_bcnt  <= '0;
            r_ws_q  <= 1'b0;
            r_sdo   <= 1'b0;
        end else if (bit_en) begin
            r_ws_q <= ws;
            r_sdo  <= (r_bcnt != '0) ? r_shreg[WIDTH-1] : 1'b0;
            if (w_slot) begin
                if (w_pop) begin
                    r_shreg <= w_load_word;
                    r_bcnt  <= frame_16 ? C_BITS_16 : C_BITS_FULL;
                end else begin
                    r_shreg <= '0;
                    r_bcnt  <= '0;
                end
            end else if (r_bcnt != '0) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                r_bcnt  <= r_bcnt - 1'b1;
            end
        end
    end

    // A set event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_cherr <= 1'b0;
        end else begin
            r_ovf   <= w_ovf_set   | (r_ovf   & ~clr_err);
            r_unf   <= w_unf_set   | (r_unf   & ~clr_err);
            r_cherr <= w_cherr_set | (r_cherr & ~clr_err);
        end
    end

    assign sdo          = r_sdo;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_level >= C_AF);
    assign almost_empty = (w_level <= C_AE);
    assign level        = w_level;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    assign ch_err       = r_cherr;

endmodule

// File: tb/tb_tx_stereo_fifo.sv
module tb_tx_stereo_fifo;

    localparam int WIDTH = 32;
    localparam int ADDR  = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst_;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             wr_ch;
    logic             bit_en;
    logic             ws;
    logic             frame_16;
    logic             flush;
    logic             clr_err;
    logic             sdo;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [ADDR:0]    level;
    logic             overflow;
    logic             underflow;
    logic             ch_err;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] cap = '0;

    tx_stereo_fifo #(.WIDTH(WIDTH), .ADDR(ADDR), .AF_LVL(AF), .AE_LVL(AE)) dut (
        .clk(clk), .rst_(rst_), .wr_en(wr_en), .din(din), .wr_ch(wr_ch),
        .bit_en(bit_en), .ws(ws), .frame_16(frame_16), .flush(flush),
        .clr_err(clr_err), .sdo(sdo), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .ch_err(ch_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH:0] mq[$];     // {tag, word} entries
    bit             mbits[$];  // bits still to appear on sdo
    bit             m_wsq = 0;
    bit             m_sdo = 0;
    bit             m_ovf = 0, m_unf = 0, m_cherr = 0;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mq.delete(); mbits.delete();
            m_wsq = 0; m_sdo = 0; m_ovf = 0; m_unf = 0; m_cherr = 0;
        end else begin
            bit was_full, was_empty, slot, so, su, sc;
            logic [WIDTH:0] e;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            slot = bit_en && (ws != m_wsq);
            so = wr_en && was_full && !flush;
            su = 0; sc = 0;
            if (bit_en) begin
                m_sdo = (mbits.size() > 0) ? mbits.pop_front() : 1'b0;
                if (slot) begin
                    mbits.delete();
                    if (!was_empty && !flush) begin
                        e = mq.pop_front();
                        if (frame_16) for (int i = 15; i >= 0; i--) mbits.push_back(e[i]);
                        else          for (int i = WIDTH-1; i >= 0; i--) mbits.push_back(e[i]);
                        sc = (e[WIDTH] != ws);
                    end else if (!flush) begin
                        su = 1;
                    end
                end
                m_wsq = ws;
            end
            if (wr_en && !was_full && !flush) mq.push_back({wr_ch, din});
            if (flush) mq.delete();
            m_ovf   = so | (m_ovf   & !clr_err);
            m_unf   = su | (m_unf   & !clr_err);
            m_cherr = sc | (m_cherr & !clr_err);
        end
    end

    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        check("cycle_outputs",
              {sdo, full, empty, almost_full, almost_empty, level, overflow, underflow, ch_err},
              {m_sdo, sz == DEPTH, sz == 0, sz >= AF, sz <= AE, 4'(sz), m_ovf, m_unf, m_cherr});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic tag, input logic [WIDTH-1:0] w);
        wr_en = 1; wr_ch = tag; din = w;
        tick();
        wr_en = 0;
    endtask

    task automatic strobe(input logic v);
        bit_en = 1; ws = v;
        tick();
        bit_en = 0;
        cap = {cap[30:0], sdo};
        tick();
    endtask

    task automatic pulse_clr();
        clr_err = 1; tick(); clr_err = 0;
    endtask

    initial begin
        rst_ = 0; wr_en = 0; din = '0; wr_ch = 0; bit_en = 0; ws = 0;
        frame_16 = 0; flush = 0; clr_err = 0;
        repeat (3) tick();
        check("reset_state", {sdo, full, empty, almost_full, almost_empty, level, overflow, underflow, ch_err},
              {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
        rst_ = 1;
        tick();

        // Empty slot start: zeros out, underflow, level stays 0
        for (int i = 0; i < 32; i++) strobe(1'b1);
        check("underflow_set", underflow, 1'b1);
        check("underflow_zero_bits", cap, 32'h0);
        check("underflow_level", level, 4'd0);
        pulse_clr();
        check("underflow_cleared", underflow, 1'b0);

        // Stereo pair, 32-bit frames
        push(1'b0, 32'hA5A5_0001);
        push(1'b1, 32'h5A5A_0002);
        check("pair_level2", level, 4'd2);
        strobe(1'b0);
        check("pair_level1", level, 4'd1);
        for (int i = 0; i < 31; i++) strobe(1'b0);
        strobe(1'b1);
        check("left_word", cap, 32'hA5A5_0001);
        check("pair_level0", level, 4'd0);
        for (int i = 0; i < 32; i++) strobe(1'b1);
        check("right_word", cap, 32'h5A5A_0002);
        check("pair_no_flags", {overflow, underflow, ch_err}, 3'b000);

        // Fill past full
        for (int i = 0; i < 8; i++) push(1'b0, 32'h100 + i);
        check("fill_level8", level, 4'd8);
        check("fill_full", {full, almost_full}, 2'b11);
        check("fill_no_ovf_yet", overflow, 1'b0);
        push(1'b0, 32'hDEAD);
        check("ovf_level", level, 4'd8);
        check("ovf_set", overflow, 1'b1);
        pulse_clr();
        check("ovf_cleared", overflow, 1'b0);
        flush = 1; tick(); flush = 0;
        check("flush_empty", {empty, level}, {1'b1, 4'd0});

        // 16-bit frame in 32-strobe slot
        frame_16 = 1;
        push(1'b0, 32'h0000_C3C3);
        for (int i = 0; i < 33; i++) strobe(1'b0);
        check("frame16_bits", cap, 32'hC3C3_0000);
        check("frame16_no_flags", {overflow, underflow, ch_err}, 3'b000);
        frame_16 = 0;

        // Channel mismatch
        strobe(1'b1);
        pulse_clr();
        push(1'b1, 32'h1234_5678);
        for (int i = 0; i < 33; i++) strobe(1'b0);
        check("cherr_set", ch_err, 1'b1);
        check("cherr_word_sent", cap, 32'h1234_5678);
        pulse_clr();
        check("cherr_cleared", ch_err, 1'b0);

        // Flush with same-cycle push
        for (int i = 0; i < 5; i++) push(1'b0, 32'h200 + i);
        check("pre_flush_level5", level, 4'd5);
        flush = 1; wr_en = 1; din = 32'hFFFF; wr_ch = 0;
        tick();
        flush = 0; wr_en = 0;
        check("flush_push_dropped", {level, empty, overflow}, {4'd0, 1'b1, 1'b0});

        // Reset mid-word
        push(1'b1, 32'hDEAD_BEEF);
        push(1'b1, 32'h0000_0001);
        strobe(1'b1);
        strobe(1'b1);
        check("pre_reset_sdo", sdo, 1'b1);
        @(posedge clk); #2;
        rst_ = 0;
        #1;
        check("async_reset", {sdo, full, empty, almost_full, almost_empty, level, overflow, underflow, ch_err},
              {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
        tick();
        rst_ = 1;
        tick();
        push(1'b1, 32'h0BAD_F00D);
        check("post_reset_level1", level, 4'd1);
        strobe(1'b1);
        check("post_reset_slot", {level, underflow, ch_err}, {4'd0, 1'b0, 1'b0});
        for (int i = 0; i < 32; i++) strobe(1'b1);
        check("post_reset_word", cap, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
